blowfish_decryption_main_code: RTL and testbench

Iterative Blowfish-style 64-bit block decryptor with a fixed 16-round Feistel network and an on-the-fly P-array derived from a 448-bit key. It is the decryption datapath of the cipher subsystem. It accepts one block per start pulse, runs one round per clock, and presents the recovered block with a one-cycle done strobe. It is the inverse of the team's matching encryption core, which shares the same package constants and F function.

---
 rtl/blowfish_pkg.sv | 51 +++++
 rtl/blowfish_f.sv | 19 +
 rtl/blowfish_decryption_main_code.sv | 108 ++++++++++
 tb/tb_blowfish_decryption_main_code.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// blowfish_pkg -- constants and helpers shared by the Blowfish-style
// encryption and decryption cores.
//   P_INIT     : 18-entry pi-digit table (P-array seed and S-box seeds)
//   NUM_ROUNDS : Feistel round count
//   bf_state_e : iterative core sequencing states
//   key_word   : 32-bit word j of the 448-bit key, word 0 at the MSB end
//   p_entry    : P[i] = P_INIT[i] ^ K[i mod 14]
//   sbox       : ROM-less S-box Sn(v) = rotl(P_INIT[n], v[4:0]) ^ {4{v}}
package blowfish_pkg;

  localparam int NUM_ROUNDS = 16;

  localparam logic [31:0] P_INIT [0:17] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } bf_state_e;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
    logic [63:0] d;
    // Upper half of the doubled word shifted left is the rotate.
    d = {v, v} << s;
    return d[63:32];
  endfunction

  function automatic logic [31:0] key_word(input logic [447:0] key, input logic [3:0] j);
    logic [447:0] sh;
    sh = key >> (32 * (13 - int'(j)));
    return sh[31:0];
  endfunction

  function automatic logic [31:0] p_entry(input logic [447:0] key, input logic [4:0] idx);
    logic [3:0] j;
    // 14 key words cycle over 18 P entries.
    j = (idx >= 5'd14) ? 4'(idx - 5'd14) : idx[3:0];
    return P_INIT[idx] ^ key_word(key, j);
  endfunction

  function automatic logic [31:0] sbox(input int n, input logic [7:0] v);
    return rotl32(P_INIT[n], v[4:0]) ^ {4{v}};
  endfunction

endpackage

// File: rtl/blowfish_f.sv
// blowfish_f -- combinational Feistel F function, shared with the encryption core.
//   x_i [31:0] : round input {a, b, c, d}, a is the MSB byte
//   f_o [31:0] : ((S0(a) + S1(b)) ^ S2(c)) + S3(d), adds mod 2^32
module blowfish_f
  import blowfish_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [31:0] f_o
);

  logic [31:0] s0, s1, s2, s3;

  assign s0  = sbox(0, x_i[31:24]);
  assign s1  = sbox(1, x_i[23:16]);
  assign s2  = sbox(2, x_i[15:8]);
  assign s3  = sbox(3, x_i[7:0]);
  assign f_o = ((s0 + s1) ^ s2) + s3;

endmodule

// File: rtl/blowfish_decryption_main_code.sv
// blowfish_decryption_main_code -- iterative 16-round Blowfish-style block
// decryptor, one round per clock, 18 cycles per block.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : block request, sampled only while idle
//   pt  [63:0] : ciphertext in, {xL, xR}
//   key [448:0]: key; bits [447:0] used, bit 448 ignored
//   ct  [63:0] : recovered block, registered, held until the next completion
//   busy       : high from accepted start until completion
//   done       : one-cycle pulse on the edge that updates ct
module blowfish_decryption_main_code
  import blowfish_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  pt,
  input  logic [448:0] key,
  output logic [63:0]  ct,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  bf_state_e    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [31:0]  xl_q, xl_d, xr_q, xr_d;
  logic [447:0] key_q, key_d;
  logic [63:0]  ct_q, ct_d;
  logic         done_q, done_d;

  logic [31:0]  p_round, xl_p, f_out;
  logic         unused_key_msb;

  assign unused_key_msb = key[448];

  // Round r consumes P[17-r]; the P-array is never stored, only muxed.
  assign p_round = p_entry(key_q, 5'd17 - {1'b0, round_q});
  assign xl_p    = xl_q ^ p_round;

  blowfish_f u_f (
    .x_i (xl_p),
    .f_o (f_out)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    round_d = round_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    key_d   = key_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROUND;
          round_d = '0;
          xl_d    = pt[63:32];
          xr_d    = pt[31:0];
          key_d   = key[447:0];
        end
      end
      ROUND: begin
        // xL ^= P; xR ^= F(xL); swap -- folded into one register update.
        xl_d    = xr_q ^ f_out;
        xr_d    = xl_p;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) state_d = FINAL;
      end
      FINAL: begin
        // Undoing the last swap puts xR_q in the left half; then whiten with P[0]/P[1].
        ct_d    = {xr_q ^ p_entry(key_q, 5'd0), xl_q ^ p_entry(key_q, 5'd1)};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      round_q <= round_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign ct   = ct_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_blowfish_decryption_main_code.sv
// tb_blowfish_decryption_main_code -- self-checking bench with an independent
// behavioural model of the cipher (array-based P table, loop-based rounds).
module tb_blowfish_decryption_main_code;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  pt;
  logic [448:0] key;
  logic [63:0]  ct;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  blowfish_decryption_main_code dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .pt    (pt),
    .key   (key),
    .ct    (ct),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [31:0] pi_tab [0:17] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B
  };

  function automatic logic [31:0] m_rotl(logic [31:0] v, int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] m_s(int n, logic [7:0] v);
    return m_rotl(pi_tab[n], int'(v) % 32) ^ {v, v, v, v};
  endfunction

  function automatic logic [31:0] m_f(logic [31:0] x);
    return ((m_s(0, x[31:24]) + m_s(1, x[23:16])) ^ m_s(2, x[15:8])) + m_s(3, x[7:0]);
  endfunction

  function automatic logic [31:0] m_p(logic [448:0] k, int i);
    int j;
    j = i % 14;
    return pi_tab[i] ^ k[447 - 32*j -: 32];
  endfunction

  function automatic logic [63:0] m_dec(logic [63:0] blk, logic [448:0] k);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 17; i >= 2; i--) begin
      l = l ^ m_p(k, i);
      r = r ^ m_f(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ m_p(k, 1);
    l = l ^ m_p(k, 0);
    return {l, r};
  endfunction

  function automatic logic [63:0] m_enc(logic [63:0] blk, logic [448:0] k);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i <= 15; i++) begin
      l = l ^ m_p(k, i);
      r = r ^ m_f(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ m_p(k, 16);
    l = l ^ m_p(k, 17);
    return {l, r};
  endfunction

  function automatic logic [448:0] rand_key();
    logic [448:0] k;
    for (int j = 0; j < 14; j++) k[j*32 +: 32] = $urandom;
    k[448] = 1'($urandom);
    return k;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns cycles from start edge to done (41 = timeout).
  task automatic run_block(input logic [63:0] blk, input logic [448:0] k,
                           output int lat, output logic [63:0] res);
    @(negedge clk);
    pt    = blk;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 41;
    res = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (done) begin
        lat = c - 1;
        res = ct;
        break;
      end
    end
  endtask

  logic [448:0] ref_key;
  logic [63:0]  ref_pt, golden, res, a_blk, b_blk, blk;
  logic [448:0] k;
  int           lat;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pt    = '0;
    key   = '0;
    repeat (2) @(negedge clk);
    check("reset_ct", ct, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Reference vector, latency and exact value.
    ref_pt  = 64'hba799b150d434cfd;
    ref_key = {1'b0, {14{32'hd5118e9d}}};
    golden  = m_dec(ref_pt, ref_key);
    run_block(ref_pt, ref_key, lat, res);
    check("ref_latency", 64'(lat), 64'd17);
    check("ref_ct", res, golden);
    check("ref_busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    check("ref_done_pulse_width", 64'(done), 64'd0);
    check("ref_ct_hold", ct, golden);

    // key[448] must not matter.
    run_block(ref_pt, {1'b1, ref_key[447:0]}, lat, res);
    check("key448_ct", res, golden);

    // Round trips through the model encryptor.
    k = '0;
    run_block(m_enc(64'h0123456789abcdef, k), k, lat, res);
    check("rt_key0", res, 64'h0123456789abcdef);
    k = {1'b0, {448{1'b1}}};
    run_block(m_enc(64'h0123456789abcdef, k), k, lat, res);
    check("rt_key1", res, 64'h0123456789abcdef);

    // Random blocks and keys.
    for (int n = 0; n < 8; n++) begin
      blk = {$urandom, $urandom};
      k   = rand_key();
      run_block(blk, k, lat, res);
      check($sformatf("rand_dec_%0d", n), res, m_dec(blk, k));
      check($sformatf("rand_lat_%0d", n), 64'(lat), 64'd17);
    end
    k = rand_key();
    blk = {$urandom, $urandom};
    run_block(m_enc(blk, k), k, lat, res);
    check("rand_roundtrip", res, blk);

    // Start pulses and input changes while busy are ignored.
    begin
      int n_done, done_at;
      logic [63:0] got;
      a_blk = {$urandom, $urandom};
      k     = rand_key();
      n_done = 0; done_at = -1; got = '0;
      @(negedge clk);
      pt = a_blk; key = k; start = 1'b1;
      for (int c = 0; c <= 40; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) begin
          n_done++;
          done_at = c;
          got = ct;
        end
        start = (c == 4 || c == 15);
        if (c == 2) begin
          pt  = {$urandom, $urandom};
          key = rand_key();
        end
      end
      check("busy_ign_done_count", 64'(n_done), 64'd1);
      check("busy_ign_done_at", 64'(done_at), 64'd17);
      check("busy_ign_ct", got, m_dec(a_blk, k));
    end

    // Back-to-back with start held high.
    begin
      int n_done, d1, d2, low_cnt;
      logic [63:0] c1, c2;
      a_blk = {$urandom, $urandom};
      b_blk = {$urandom, $urandom};
      k     = rand_key();
      n_done = 0; d1 = -1; d2 = -1; low_cnt = 0; c1 = '0; c2 = '0;
      @(negedge clk);
      pt = a_blk; key = k; start = 1'b1;
      for (int c = 0; c <= 60; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c == 0) pt = b_blk;
        if (done) begin
          n_done++;
          if (n_done == 1) begin d1 = c; c1 = ct; end
          else begin d2 = c; c2 = ct; end
        end
        if (n_done == 1 && !busy) low_cnt++;
        if (n_done == 2) begin
          start = 1'b0;
          break;
        end
      end
      start = 1'b0;
      check("b2b_first_done", 64'(d1), 64'd17);
      check("b2b_spacing", 64'(d2 - d1), 64'd18);
      check("b2b_ct_a", c1, m_dec(a_blk, k));
      check("b2b_ct_b", c2, m_dec(b_blk, k));
      check("b2b_busy_low", 64'(low_cnt), 64'd1);
    end

    // Reset mid-run at r = 7.
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      pt = {$urandom, $urandom}; key = rand_key(); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ct", ct, 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'd0);
    end

    // Recovery after reset.
    run_block(ref_pt, ref_key, lat, res);
    check("recover_ct", res, golden);
    check("recover_latency", 64'(lat), 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
